// File: rtl/spi_slave.sv
// spi_slave: SPI serial front end; 10-bit MOSI frames in, 8-bit read responses out on MISO.
// Optional macro SPI_SLAVE_RD_TRACK_EN resolves read-address/read-data frames via rd_addr_seen.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_TX, PH_HOLD} phase_t;

    state_t     state_q;
    phase_t     phase_q;
    logic [3:0] cnt_q;
    logic [8:0] rx_sr_q;
    logic [6:0] tx_sr_q;
    logic [9:0] rx_data_q;
    logic       rx_valid_q;
    logic       miso_q;
`ifdef SPI_SLAVE_RD_TRACK_EN
    logic       rd_addr_seen_q;
`endif

    // Complete frame as it stands on the edge that samples bit 0.
    logic [9:0] frame_d;
    assign frame_d = {rx_sr_q, MOSI};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= PH_RX;
            cnt_q      <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
`ifdef SPI_SLAVE_RD_TRACK_EN
            rd_addr_seen_q <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q != IDLE && SS_n) begin
                state_q <= IDLE;
                phase_q <= PH_RX;
                cnt_q   <= '0;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        miso_q  <= 1'b0;
                        phase_q <= PH_RX;
                        rx_sr_q <= '0;
                        if (!SS_n) begin
                            state_q <= CHK_CMD;
                            cnt_q   <= 4'd9;
                        end
                    end
                    CHK_CMD: begin
                        rx_sr_q <= {rx_sr_q[7:0], MOSI};
                        cnt_q   <= 4'd8;
                        phase_q <= PH_RX;
                        if (!MOSI) begin
                            state_q <= WRITE;
`ifdef SPI_SLAVE_RD_TRACK_EN
                        end else if (rd_addr_seen_q) begin
                            state_q <= READ_DATA;
`endif
                        end else begin
                            state_q <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        case (phase_q)
                            PH_RX: begin
                                if (cnt_q == 4'd0) begin
                                    rx_data_q  <= frame_d;
                                    rx_valid_q <= 1'b1;
                                    phase_q    <= PH_HOLD;
                                    if (state_q == READ_DATA) begin
                                        phase_q <= PH_WAIT;
                                        cnt_q   <= 4'd7;
                                    end
`ifdef SPI_SLAVE_RD_TRACK_EN
                                    if (state_q == READ_ADD)
                                        rd_addr_seen_q <= 1'b1;
`else
                                    if (state_q == READ_ADD && frame_d[9:8] == 2'b11) begin
                                        state_q <= READ_DATA;
                                        phase_q <= PH_WAIT;
                                        cnt_q   <= 4'd7;
                                    end
`endif
                                end else begin
                                    rx_sr_q <= {rx_sr_q[7:0], MOSI};
                                    cnt_q   <= cnt_q - 4'd1;
                                end
                            end
                            PH_WAIT: begin
                                // Bit 7 goes straight to MISO so it is valid the cycle after the latch.
                                if (tx_valid) begin
                                    tx_sr_q <= tx_data[6:0];
                                    miso_q  <= tx_data[7];
                                    cnt_q   <= 4'd7;
                                    phase_q <= PH_TX;
                                end
                            end
                            PH_TX: begin
                                if (cnt_q == 4'd0) begin
                                    miso_q  <= 1'b0;
                                    phase_q <= PH_HOLD;
`ifdef SPI_SLAVE_RD_TRACK_EN
                                    rd_addr_seen_q <= 1'b0;
`endif
                                end else begin
                                    miso_q  <= tx_sr_q[6];
                                    tx_sr_q <= {tx_sr_q[5:0], 1'b0};
                                    cnt_q   <= cnt_q - 4'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed frames; rx_data checked by a queue-based scoreboard monitor, MISO checked per cycle.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

`ifdef SPI_SLAVE_RD_TRACK_EN
    localparam bit RD_TRACK = 1'b1;
`else
    localparam bit RD_TRACK = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid strobe must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("rx_data", {22'd0, rx_data}, {22'd0, e});
            end
        end
    end

    task automatic start_frame();
        @(negedge clk);
        SS_n = 1'b0;
    endtask

    // Drives bits 9 down to (10-n); counts cycles where MISO was not 0.
    task automatic shift_bits(input logic [9:0] f, input int n, output int miso_hi);
        miso_hi = 0;
        for (int i = 9; i > 9 - n; i--) begin
            @(negedge clk);
            if (MISO !== 1'b0) miso_hi++;
            MOSI = f[i];
        end
    endtask

    task automatic full_frame(input logic [9:0] f, input string name);
        int m;
        exp_q.push_back(f);
        start_frame();
        shift_bits(f, 10, m);
        check({name, "_miso_quiet"}, m, 0);
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
    endtask

    // Called right after bit 0 is driven; returns tx_valid one cycle after the rx_valid cycle.
    task automatic tx_phase(input logic [7:0] d, input bit shift_en, input string name, input int stop_at);
        @(negedge clk);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = '0;
            check($sformatf("%s_miso_b%0d", name, i), {31'd0, MISO}, {31'd0, shift_en ? d[i] : 1'b0});
            if (i == stop_at) begin
                rst_n = 1'b0;
                SS_n  = 1'b1;
                return;
            end
        end
        @(negedge clk);
        check({name, "_miso_end"}, {31'd0, MISO}, 32'd0);
    endtask

    initial begin
        int m;
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_miso", {31'd0, MISO}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {22'd0, rx_data}, 32'd0);
        rst_n = 1'b1;

        // Write address; a stray tx_valid while holding must not reach MISO.
        full_frame(10'h03C, "wr_addr");
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = '0;
        check("wr_addr_miso_hold0", {31'd0, MISO}, 32'd0);
        @(negedge clk);
        check("wr_addr_miso_hold1", {31'd0, MISO}, 32'd0);
        end_frame();

        // Write data; SS_n high for exactly one cycle before the next frame.
        full_frame(10'h1A5, "wr_data");
        end_frame();

        // Read address then read data with 0xA5 response.
        full_frame(10'h23C, "rd_addr");
        end_frame();
        full_frame(10'h355, "rd_data");
        tx_phase(8'hA5, 1'b1, "rd", -1);
        end_frame();

        // rd_addr_seen cleared: with tracking this 11 frame is a read address again.
        full_frame(10'h3C3, "rd_again");
        tx_phase(8'h3C, !RD_TRACK, "rd_again", -1);
        end_frame();

        // Abort after 5 bits, then a full frame right behind it.
        start_frame();
        shift_bits(10'h0F0, 5, m);
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        check("abort_rx_hold", {22'd0, rx_data}, 32'h3C3);
        full_frame(10'h0AB, "after_abort");
        end_frame();

        // SS_n rising on the bit-0 sample edge is an abort.
        start_frame();
        shift_bits(10'h155, 9, m);
        @(negedge clk);
        MOSI = 1'b1;
        SS_n = 1'b1;
        @(negedge clk);
        check("bit0_abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("bit0_abort_rx_data", {22'd0, rx_data}, 32'h0AB);
        @(negedge clk);
        check("bit0_abort_rx_valid2", {31'd0, rx_valid}, 32'd0);

        // Reset during MISO bit 4.
        full_frame(10'h3FF, "rst_frame");
        tx_phase(8'h5A, 1'b1, "rst", 4);
        @(negedge clk);
        check("rst_mid_miso", {31'd0, MISO}, 32'd0);
        check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_rx_data", {22'd0, rx_data}, 32'd0);
        rst_n = 1'b1;

        // After reset a 10 frame is a read address: tx_valid must not shift out.
        full_frame(10'h2A5, "post_rst");
        tx_phase(8'h81, 1'b0, "post_rst", -1);
        end_frame();

        // Read data frame with no prior read address.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        full_frame(10'h300, "rd_noaddr");
        tx_phase(8'hC3, !RD_TRACK, "rd_noaddr", -1);
        end_frame();

        repeat (4) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI wrapper. Receives 10-bit command/data frames on MOSI under an active-low slave select and presents them in parallel to the on-chip memory. On read-data frames it collects the 8-bit memory response and shifts it back on MISO. The block sits directly upstream of the memory block; its `rx_data`/`rx_valid` outputs drive the memory's `din`/`rx_valid` inputs, and it consumes the memory's `dout`/`tx_valid`.

## Interface
- No parameters. Frame length is fixed at 10 bits; response length is fixed at 8 bits.
- `clk` input, 1 bit: system clock. It also serves as the SPI bit clock; one bit is transferred per rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `SS_n` input, 1 bit: slave select, active low. A frame spans one low period.
- `MOSI` input, 1 bit: serial data in, MSB first.
- `MISO` output, 1 bit: serial data out, MSB first.
- `rx_data` output, 10 bits: received frame. Bits [9:8] are the command: 00 write address, 01 write data, 10 read address, 11 read data.
- `rx_valid` output, 1 bit: one-cycle strobe qualifying `rx_data`.
- `tx_data` input, 8 bits: memory read result.
- `tx_valid` input, 1 bit: qualifies `tx_data`.

## Operation
- The state machine has five states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: when `SS_n` is sampled low, go to CHK_CMD. Otherwise stay.
- CHK_CMD: sample `MOSI` as frame bit 9.
  - If the bit is 0, go to WRITE.
  - If the bit is 1 and `rd_addr_seen` is 0, go to READ_ADD.
  - If the bit is 1 and `rd_addr_seen` is 1, go to READ_DATA.
- WRITE and READ_ADD: shift in bits 8..0, one per clock. After bit 0:
  - drive `rx_data` and pulse `rx_valid`;
  - hold in the state until `SS_n` goes high;
  - a completed READ_ADD frame sets `rd_addr_seen`.
- READ_DATA: shift in bits 8..0 and pulse `rx_valid` as above. Then wait for `tx_valid`.
  - On `tx_valid`, latch `tx_data` into the TX shift register.
  - Drive bits 7..0 on `MISO`, one per clock, starting the cycle after the latch.
  - After bit 0 is driven, clear `rd_addr_seen` and force `MISO` to 0.
- `SS_n` high in any non-IDLE state aborts the frame:
  - next state is IDLE;
  - no `rx_valid` is issued for a partial frame;
  - `MISO` goes to 0;
  - `rd_addr_seen` is unchanged.
- `tx_valid` is ignored in every state except READ_DATA-after-receive.
- A bit counter of 4 bits counts 9 down to 0 while receiving and 7 down to 0 while transmitting. It reloads on every state entry.

## Timing
- Reset values: state IDLE, `rx_data` 0, `rx_valid` 0, `MISO` 0, `rd_addr_seen` 0, counter 0.
- Reset asserted mid-frame takes effect at the next rising edge and discards the frame entirely.
- Latency from the `SS_n` low sample to the bit-9 sample is 1 cycle.
- A full frame takes 11 edges: IDLE detect, plus 10 bits.
- `rx_valid` is high for exactly one cycle, starting the cycle after bit 0 is sampled. `rx_data` holds its value until the next frame completes.
- MISO timing: bit 7 is valid the cycle after the `tx_valid` sample. Each following bit is valid one cycle later, and `MISO` returns to 0 after 8 bits.
- The memory's single-cycle `tx_valid` response is sufficient. No timeout applies; the block waits for `tx_valid` indefinitely while `SS_n` stays low.
- `SS_n` rising in the same cycle as the bit-0 sample counts as an abort: no `rx_valid`.

## Configuration
- Macro: `SPI_SLAVE_RD_TRACK_EN`.
- Defined: read-address versus read-data frames are resolved in CHK_CMD by `rd_addr_seen`, exactly as described above.
- Undefined:
  - `rd_addr_seen` is removed;
  - MOSI=1 in CHK_CMD always goes to READ_ADD;
  - after the 10-bit receive, a frame with `rx_data[9:8]`=11 enters the READ_DATA transmit phase (wait `tx_valid`, shift 8 bits);
  - any other command value waits for `SS_n` high.

## Test plan
- Write address: send 0x0_3C as 00_00111100. Required: `rx_data`=0x03C with a one-cycle `rx_valid`; `MISO` stays 0.
- Write data: send 01_10100101. Required: `rx_data`=0x1A5 and `rx_valid` pulse. Then `SS_n` high returns the block to IDLE the next cycle.
- Read sequence: send 10_00111100, then 11_xxxxxxxx. Return `tx_valid` with `tx_data`=0xA5 one cycle after `rx_valid`. Required: `rx_data`=0x23C then 0x3xx; `MISO` bits 1,0,1,0,0,1,0,1 on consecutive cycles; `rd_addr_seen` cleared afterwards.
- Abort: raise `SS_n` after 5 bits of a write frame. Required: no `rx_valid`; state IDLE next cycle. A following full frame is received correctly.
- Reset mid-transmit: assert `rst_n`=0 during MISO bit 4. Required: all outputs 0 on the next edge; `rd_addr_seen`=0, so the next frame starting with 1 goes to READ_ADD.
- With `SPI_SLAVE_RD_TRACK_EN` undefined: send 11 frame with no prior read address. Required: `rx_valid`, then an 8-bit MISO shift of `tx_data`.
